// File: rtl/sensor_sched_pkg.sv
// Shared types and constants for the sensor poll scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sensor_sched_pkg;

  localparam int TIMER_W = 24;

  localparam logic [15:0] NEAR_TH_DEF = 16'd80;
  localparam logic [15:0] FAR_TH_DEF  = 16'd40;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    WAIT    = 2'd2,
    FAULT   = 2'd3
  } state_t;

endpackage

// File: rtl/prox_hysteresis.sv
// Two-threshold proximity flag, updated only when a new sample is captured.
// Latency: near reflects value one cycle after the update strobe.
// Backpressure: none; every update strobe is consumed.
module prox_hysteresis
  import sensor_sched_pkg::*;
#(
  parameter logic [15:0] NEAR_TH = NEAR_TH_DEF,
  parameter logic [15:0] FAR_TH  = FAR_TH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic [15:0] value,
  output logic        near
);

  // Values between the thresholds keep the previous decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      near <= 1'b0;
    end else if (update) begin
      if (value >= NEAR_TH) begin
        near <= 1'b1;
      end else if (value <= FAR_TH) begin
        near <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Sequences the proximity/ALS driver: enable window, timeout, retry, sticky fault, idle gap.
// Latency: a drv_data_ready strobe is published on prox_out/sample_valid one cycle later.
// Backpressure: none; a strobe is captured only in ACQUIRE and ignored elsewhere.
module sensor_poll_scheduler
  import sensor_sched_pkg::*;
#(
  parameter logic [TIMER_W-1:0] POLL_PERIOD = 24'd1_200_000,
  parameter logic [TIMER_W-1:0] TIMEOUT     = 24'd12_000_000,
  parameter logic [3:0]         MAX_RETRY   = 4'd3,
  parameter logic [15:0]        NEAR_TH     = NEAR_TH_DEF,
  parameter logic [15:0]        FAR_TH      = FAR_TH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        clear_fault,
  output logic        drv_enable,
  input  logic        drv_data_ready,
  input  logic        drv_error,
  input  logic [15:0] drv_prox,
  input  logic [15:0] drv_als,
  output logic [15:0] prox_out,
  output logic [15:0] als_out,
  output logic        sample_valid,
  output logic        hand_near,
  output logic [7:0]  sample_count,
  output logic        busy,
  output logic        fault
);

  // Terminal counts; both parameters are at least 1 so these never wrap.
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMEOUT - 24'd1;
  localparam logic [TIMER_W-1:0] POLL_LAST    = POLL_PERIOD - 24'd1;

  state_t               state, state_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [3:0]           retry_cnt, retry_nxt;
  logic [3:0]           retry_inc;
  logic                 capture;

  assign retry_inc = retry_cnt + 4'd1;

  // State, timer and retry counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      retry_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // Next-state logic; timer is cleared on every state change so each
  // window and each gap starts counting from zero.
  always_comb begin
    state_nxt = state;
    timer_nxt = '0;
    retry_nxt = retry_cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_nxt = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (drv_data_ready) begin
          // Data beats a coincident error.
          capture   = 1'b1;
          retry_nxt = 4'd0;
          state_nxt = WAIT;
        end else if (drv_error || (timer == TIMEOUT_LAST)) begin
          retry_nxt = retry_inc;
          state_nxt = (retry_inc == MAX_RETRY) ? FAULT : WAIT;
        end else begin
          timer_nxt = timer + 24'd1;
        end
      end
      WAIT: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (timer == POLL_LAST) begin
          state_nxt = ACQUIRE;
        end else begin
          timer_nxt = timer + 24'd1;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_nxt = IDLE;
          retry_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered status outputs decoded from the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_enable   <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      drv_enable   <= (state_nxt == ACQUIRE);
      busy         <= (state_nxt == ACQUIRE) || (state_nxt == WAIT);
      fault        <= (state_nxt == FAULT);
      sample_valid <= capture;
    end
  end

  // Sample capture; values persist until the next successful acquisition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prox_out     <= 16'd0;
      als_out      <= 16'd0;
      sample_count <= 8'd0;
    end else if (capture) begin
      prox_out     <= drv_prox;
      als_out      <= drv_als;
      sample_count <= sample_count + 8'd1;
    end
  end

  prox_hysteresis #(
    .NEAR_TH (NEAR_TH),
    .FAR_TH  (FAR_TH)
  ) u_hyst (
    .clk    (clk),
    .rst    (rst),
    .update (capture),
    .value  (drv_prox),
    .near   (hand_near)
  );

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Self-checking bench for sensor_poll_scheduler with a driver stub and sample scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_sensor_poll_scheduler;

  logic        clk = 1'b0;
  logic        rst, run, clear_fault;
  logic        drv_enable, drv_data_ready, drv_error;
  logic [15:0] drv_prox, drv_als, prox_out, als_out;
  logic        sample_valid, hand_near, busy, fault;
  logic [7:0]  sample_count;

  always #5 clk = ~clk;

  sensor_poll_scheduler #(
    .POLL_PERIOD (24'd4),
    .TIMEOUT     (24'd20),
    .MAX_RETRY   (4'd3),
    .NEAR_TH     (16'd80),
    .FAR_TH      (16'd40)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .clear_fault    (clear_fault),
    .drv_enable     (drv_enable),
    .drv_data_ready (drv_data_ready),
    .drv_error      (drv_error),
    .drv_prox       (drv_prox),
    .drv_als        (drv_als),
    .prox_out       (prox_out),
    .als_out        (als_out),
    .sample_valid   (sample_valid),
    .hand_near      (hand_near),
    .sample_count   (sample_count),
    .busy           (busy),
    .fault          (fault)
  );

  typedef struct {
    logic [15:0] prox;
    logic [15:0] als;
    logic        near;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct {
    logic [15:0] prox;
    logic        near;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[12];

  int checks = 0;
  int errors = 0;

  // Stub request mailbox: main bumps stub_req, stub acknowledges via stub_done.
  int          stub_req = 0;
  int          stub_done = 0;
  int          stub_k = 1;
  logic        stub_is_err = 1'b0;
  logic        stub_err_with = 1'b0;
  logic [15:0] stub_prox = 16'd0;
  logic [15:0] stub_als = 16'd0;
  int          acq_cyc;

  logic [7:0]  exp_cnt;
  logic        near_st;
  logic [15:0] last_prox;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired before the DUT event", name);
  endtask

  function automatic logic near_model(input logic [15:0] p, input logic prev);
    if (p >= 16'd80) return 1'b1;
    if (p <= 16'd40) return 1'b0;
    return prev;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver stub: counts cycles of the current enable window and fires a
  // single requested strobe (data or error) on the chosen cycle.
  initial begin
    drv_data_ready = 1'b0;
    drv_error      = 1'b0;
    drv_prox       = 16'd0;
    drv_als        = 16'd0;
    acq_cyc        = 0;
    forever begin
      @(posedge clk);
      #2;
      drv_data_ready = 1'b0;
      drv_error      = 1'b0;
      if (drv_enable) acq_cyc++;
      else acq_cyc = 0;
      if (stub_req != stub_done && acq_cyc == stub_k) begin
        stub_done = stub_req;
        if (stub_is_err) begin
          drv_error = 1'b1;
        end else begin
          drv_data_ready = 1'b1;
          drv_prox       = stub_prox;
          drv_als        = stub_als;
          drv_error      = stub_err_with;
        end
      end
    end
  end

  // Scoreboard monitor: every sample_valid pulse must match the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sample_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got prox 0x%0h, expected no sample", prox_out);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_prox", 32'(prox_out), 32'(mon_e.prox));
          chk("sb_als", 32'(als_out), 32'(mon_e.als));
          chk("sb_near", 32'(hand_near), 32'(mon_e.near));
          chk("sb_count", 32'(sample_count), 32'(mon_e.cnt));
          chk("sb_enable_low", 32'(drv_enable), 32'd0);
        end
      end
    end
  end

  task automatic wait_sample(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!sample_valid && lat < 60);
    if (!sample_valid) fail_bound("wait_sample");
  endtask

  task automatic wait_acq_start();
    int n = 0;
    while (!drv_enable && n < 60) begin
      tick();
      n++;
    end
    if (!drv_enable) fail_bound("wait_acq_start");
  endtask

  // Call at the first cycle of an ACQUIRE window.
  task automatic do_sample(input logic [15:0] p, input logic [15:0] a, input logic nr,
                           input int k, input logic err, output int lat);
    stub_prox     = p;
    stub_als      = a;
    stub_err_with = err;
    stub_is_err   = 1'b0;
    stub_k        = k;
    stub_req++;
    exp_cnt   = exp_cnt + 8'd1;
    sb.push_back('{p, a, nr, exp_cnt});
    last_prox = p;
    near_st   = nr;
    wait_sample(lat);
  endtask

  // Call at the first cycle of an ACQUIRE window; error fires on cycle 2.
  task automatic do_error(input logic expect_fault);
    int n = 0;
    stub_is_err = 1'b1;
    stub_k      = 2;
    stub_req++;
    while (drv_enable && n < 60) begin
      tick();
      n++;
    end
    if (drv_enable) fail_bound("do_error_window");
    chk("fault_after_error", 32'(fault), 32'(expect_fault));
    if (!expect_fault) wait_acq_start();
  endtask

  task automatic measure(input logic level, output int n);
    n = 0;
    while (drv_enable === level && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_drv_enable"}, 32'(drv_enable), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_hand_near"}, 32'(hand_near), 32'd0);
    chk({tag, "_count"}, 32'(sample_count), 32'd0);
    chk({tag, "_prox"}, 32'(prox_out), 32'd0);
    chk({tag, "_als"}, 32'(als_out), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w1, w2, w3, l1, l2;
    logic [15:0] p;

    tbl[0]  = '{16'd100, 1'b1};
    tbl[1]  = '{16'd60,  1'b1};
    tbl[2]  = '{16'd30,  1'b0};
    tbl[3]  = '{16'd60,  1'b0};
    tbl[4]  = '{16'd85,  1'b1};
    tbl[5]  = '{16'd80,  1'b1};
    tbl[6]  = '{16'd79,  1'b1};
    tbl[7]  = '{16'd41,  1'b1};
    tbl[8]  = '{16'd40,  1'b0};
    tbl[9]  = '{16'd79,  1'b0};
    tbl[10] = '{16'd80,  1'b1};
    tbl[11] = '{16'd39,  1'b0};

    rst = 1'b1;
    run = 1'b0;
    clear_fault = 1'b0;
    exp_cnt = 8'd0;
    near_st = 1'b0;
    last_prox = 16'd0;

    tick();
    tick();
    chk_all_zero("reset");

    rst = 1'b0;
    run = 1'b1;
    tick();
    chk("start_enable", 32'(drv_enable), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);

    // Normal poll: strobe on the 5th ACQUIRE cycle.
    do_sample(16'd100, 16'h0200, 1'b1, 5, 1'b0, lat);
    chk("capture_latency", 32'(lat), 32'd5);
    tick();
    chk("valid_one_cycle", 32'(sample_valid), 32'd0);
    tick();
    tick();
    chk("enable_low_in_gap", 32'(drv_enable), 32'd0);
    chk("busy_in_gap", 32'(busy), 32'd1);
    tick();
    chk("enable_reasserts", 32'(drv_enable), 32'd1);

    // Asynchronous reset in the middle of an ACQUIRE window.
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    exp_cnt = 8'd0;
    near_st = 1'b0;
    last_prox = 16'd0;
    tick();
    rst = 1'b0;
    tick();
    chk("release_enable", 32'(drv_enable), 32'd1);

    // Hysteresis vectors.
    for (int i = 0; i < 12; i++) begin
      wait_acq_start();
      do_sample(tbl[i].prox, 16'(i + 16'h0100), tbl[i].near, 2, 1'b0, lat);
      chk("hyst_table", 32'(hand_near), 32'(tbl[i].near));
    end

    // Timeout path to FAULT: three 20-cycle windows split by 4-cycle gaps.
    wait_acq_start();
    measure(1'b1, w1);
    measure(1'b0, l1);
    measure(1'b1, w2);
    measure(1'b0, l2);
    measure(1'b1, w3);
    chk("timeout_window1", 32'(w1), 32'd20);
    chk("timeout_gap1", 32'(l1), 32'd4);
    chk("timeout_window2", 32'(w2), 32'd20);
    chk("timeout_gap2", 32'(l2), 32'd4);
    chk("timeout_window3", 32'(w3), 32'd20);
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_enable", 32'(drv_enable), 32'd0);
    run = 1'b0;
    repeat (3) tick();
    run = 1'b1;
    repeat (3) tick();
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_enable_held", 32'(drv_enable), 32'd0);
    chk("fault_not_busy", 32'(busy), 32'd0);
    chk("fault_prox_held", 32'(prox_out), 32'(last_prox));
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clear_fault_cleared", 32'(fault), 32'd0);
    chk("clear_fault_idle", 32'(busy), 32'd0);
    tick();
    chk("clear_fault_restart", 32'(drv_enable), 32'd1);

    // Data and error together: data wins, no failure counted.
    do_sample(16'd30, 16'h0030, 1'b0, 3, 1'b1, lat);
    wait_acq_start();
    do_error(1'b0);
    do_error(1'b0);
    do_sample(16'd90, 16'h0090, 1'b1, 2, 1'b0, lat);
    wait_acq_start();
    do_error(1'b0);
    do_error(1'b0);
    do_error(1'b1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    wait_acq_start();

    // run dropped in ACQUIRE, then in WAIT.
    tick();
    run = 1'b0;
    tick();
    chk("run_off_acq_enable", 32'(drv_enable), 32'd0);
    chk("run_off_acq_busy", 32'(busy), 32'd0);
    chk("run_off_acq_prox", 32'(prox_out), 32'(last_prox));
    run = 1'b1;
    tick();
    chk("run_on_enable", 32'(drv_enable), 32'd1);
    do_sample(16'd50, 16'h0050, near_model(16'd50, near_st), 1, 1'b0, lat);
    run = 1'b0;
    tick();
    chk("run_off_wait_busy", 32'(busy), 32'd0);
    chk("run_off_wait_enable", 32'(drv_enable), 32'd0);
    chk("run_off_wait_prox", 32'(prox_out), 32'd50);
    run = 1'b1;
    wait_acq_start();

    // Keep capturing until the 8-bit count wraps.
    do begin
      wait_acq_start();
      p = 16'($urandom_range(0, 120));
      do_sample(p, ~p, near_model(p, near_st), 1, 1'b0, lat);
    end while (exp_cnt != 8'd0);
    chk("count_wrap", 32'(sample_count), 32'd0);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
